// File: rtl/save_slot_store_pkg.sv
// Shared definitions for the save/load snapshot store: the slot codes driven by
// the VGA controller, the save FSM encoding and the default sensor word width.
package save_slot_store_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] CODE_NONE = 32'd0;
  localparam logic [31:0] CODE_LOC1 = 32'd1;
  localparam logic [31:0] CODE_LOC2 = 32'd2;
  localparam logic [31:0] CODE_LOC3 = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2
  } save_state_e;

endpackage

// File: rtl/save_slot_store_bank.sv
// Snapshot register file: one word plus a valid bit per slot, slots addressed 1..NUM_SLOTS
// (index 0 means no slot). Combinational read, valid bits cleared by reset.
module slot_bank #(
  parameter int DATA_W    = 32,
  parameter int NUM_SLOTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_widx,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [IDX_W-1:0]     i_ridx,
  output logic [DATA_W-1:0]    o_rdata,
  output logic                 o_rvalid,
  output logic [NUM_SLOTS-1:0] o_valid
);

  logic [DATA_W-1:0]    r_mem [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_valid;
  logic [IDX_W-1:0]     w_wsel;
  logic [IDX_W-1:0]     w_rsel;

  assign w_wsel = i_widx - IDX_W'(1);
  assign w_rsel = i_ridx - IDX_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[w_wsel] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_valid         <= '0;
    else if (i_we) r_valid[w_wsel] <= 1'b1;
  end

  assign o_rvalid = (i_ridx != '0) && r_valid[w_rsel];
  assign o_rdata  = (i_ridx != '0) ? r_mem[w_rsel] : '0;
  assign o_valid  = r_valid;

endmodule

// File: rtl/save_slot_store.sv
// Save/load snapshot store: OR-accumulates sensor hits while a save slot is held,
// commits on release, and returns the selected snapshot through a registered load path.
module save_slot_store
  import save_slot_store_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_SLOTS = 3
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic [31:0]          save_signal,
  input  logic [DATA_W-1:0]    sensor_input_to_save,
  input  logic [31:0]          load_signal,
  output logic [DATA_W-1:0]    sensor_output,
  output logic                 load_valid,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 save_done,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_SLOTS + 1);

  function automatic logic [IDX_W-1:0] decode_slot(input logic [31:0] code);
    if (code != CODE_NONE && code <= 32'(NUM_SLOTS)) return code[IDX_W-1:0];
    return '0;
  endfunction

  save_state_e       r_state, w_next_state;
  logic [IDX_W-1:0]  w_save_slot, w_load_slot, r_prev_save, r_slot_idx;
  logic [DATA_W-1:0] r_acc, r_sensor_output, w_rdata;
  logic              w_start, w_accum, w_commit, w_fwd, w_rvalid;
  logic              r_load_valid, r_save_done;

  assign w_save_slot = decode_slot(save_signal);
  assign w_load_slot = decode_slot(load_signal);

  // A capture only arms on a NONE->slot edge of the decoded save code.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_accum      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_save_slot != '0 && r_prev_save == '0) begin
          w_start      = 1'b1;
          w_next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_save_slot == r_slot_idx) w_accum      = 1'b1;
        else                           w_next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prev_save <= '0;
      r_save_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_prev_save <= w_save_slot;
      r_save_done <= w_commit;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (w_start) begin
      r_slot_idx <= w_save_slot;
      r_acc      <= sensor_input_to_save;
    end else if (w_accum) begin
      r_acc <= r_acc | sensor_input_to_save;
    end
  end

  slot_bank #(
    .DATA_W    (DATA_W),
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_bank (
    .i_clk    (vga_clk),
    .i_rst    (reset),
    .i_we     (w_commit),
    .i_widx   (r_slot_idx),
    .i_wdata  (r_acc),
    .i_ridx   (w_load_slot),
    .o_rdata  (w_rdata),
    .o_rvalid (w_rvalid),
    .o_valid  (slot_valid)
  );

  // Forward the accumulator so a load of the slot being committed never shows the old word.
  assign w_fwd = w_commit && (w_load_slot != '0) && (w_load_slot == r_slot_idx);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_sensor_output <= '0;
      r_load_valid    <= 1'b0;
    end else if (w_fwd) begin
      r_sensor_output <= r_acc;
      r_load_valid    <= 1'b1;
    end else if (w_rvalid) begin
      r_sensor_output <= w_rdata;
      r_load_valid    <= 1'b1;
    end else begin
      r_sensor_output <= '0;
      r_load_valid    <= 1'b0;
    end
  end

  assign sensor_output = r_sensor_output;
  assign load_valid    = r_load_valid;
  assign save_done     = r_save_done;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_save_slot_store.sv
// Directed bench for save_slot_store: save/load, invalid codes, re-arm, slot switch,
// forwarding, overwrite and reset during capture, with hand-computed expectations.
module tb_save_slot_store;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [31:0] save_signal;
  logic [31:0] sensor_input_to_save;
  logic [31:0] load_signal;
  logic [31:0] sensor_output;
  logic        load_valid;
  logic [2:0]  slot_valid;
  logic        save_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int done_ref;

  save_slot_store #(.DATA_W(32), .NUM_SLOTS(3)) dut (
    .vga_clk              (vga_clk),
    .reset                (reset),
    .save_signal          (save_signal),
    .sensor_input_to_save (sensor_input_to_save),
    .load_signal          (load_signal),
    .sensor_output        (sensor_output),
    .load_valid           (load_valid),
    .slot_valid           (slot_valid),
    .save_done            (save_done),
    .busy                 (busy)
  );

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) if (save_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; save_signal = 0; sensor_input_to_save = 0; load_signal = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out", sensor_output, 0);
    chk("rst_lv", {31'd0, load_valid}, 0);
    chk("rst_sv", {29'd0, slot_valid}, 0);
    chk("rst_done", {31'd0, save_done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // empty and out-of-range loads
    load_signal = 2; tick();
    chk("empty_out", sensor_output, 0);
    chk("empty_lv", {31'd0, load_valid}, 0);
    load_signal = 7; tick();
    chk("inv_out", sensor_output, 0);
    chk("inv_lv", {31'd0, load_valid}, 0);
    load_signal = 0;

    // basic save into slot 1: 0x1 | 0x4 | 0x0 | 0x40 = 0x45
    done_ref = done_cnt;
    save_signal = 1; sensor_input_to_save = 32'h1;  tick();
    chk("cap_busy", {31'd0, busy}, 1);
    sensor_input_to_save = 32'h4;  tick();
    sensor_input_to_save = 32'h0;  tick();
    sensor_input_to_save = 32'h40; tick();
    save_signal = 0; sensor_input_to_save = 32'hFF; tick();
    chk("commit_busy", {31'd0, busy}, 1);
    chk("commit_sv", {29'd0, slot_valid}, 0);
    chk("commit_done", {31'd0, save_done}, 0);
    tick();
    chk("wr_done", {31'd0, save_done}, 1);
    chk("wr_sv", {29'd0, slot_valid}, 32'h1);
    chk("wr_busy", {31'd0, busy}, 0);
    load_signal = 1; tick();
    chk("basic_out", sensor_output, 32'h45);
    chk("basic_lv", {31'd0, load_valid}, 1);
    chk("basic_done_low", {31'd0, save_done}, 0);
    chk("basic_done_cnt", done_cnt - done_ref, 1);

    // re-arm: hold slot 3 for 20 cycles, one bit per cycle -> 0xFFFFF
    load_signal = 3; done_ref = done_cnt;
    for (int i = 0; i < 20; i++) begin
      save_signal = 3; sensor_input_to_save = 32'h1 << i; tick();
    end
    chk("hold_busy", {31'd0, busy}, 1);
    chk("hold_done_cnt", done_cnt - done_ref, 0);
    save_signal = 0; sensor_input_to_save = 0; tick();
    tick();
    chk("hold_fwd_out", sensor_output, 32'h000F_FFFF);
    chk("hold_sv", {29'd0, slot_valid}, 32'h5);
    tick();
    chk("hold_done_cnt1", done_cnt - done_ref, 1);
    chk("hold_mem_out", sensor_output, 32'h000F_FFFF);
    // capture slot 3, leave via slot 1, then hold 3 with no NONE in between
    save_signal = 3; sensor_input_to_save = 32'h5; tick();
    save_signal = 1; sensor_input_to_save = 32'hF; tick();
    tick();
    chk("sw3_out", sensor_output, 32'h5);
    save_signal = 3;
    for (int i = 0; i < 10; i++) tick();
    chk("norearm_busy", {31'd0, busy}, 0);
    chk("norearm_cnt", done_cnt - done_ref, 2);
    chk("norearm_out", sensor_output, 32'h5);

    // slot switch 1 -> 2: slot 1 gets 0x0F|0x30, the 0xF0 cycle is not accumulated
    save_signal = 0; tick();
    save_signal = 1; sensor_input_to_save = 32'h0F; tick();
    sensor_input_to_save = 32'h30; tick();
    save_signal = 2; sensor_input_to_save = 32'hF0; tick();
    tick();
    load_signal = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("switch_out", sensor_output, 32'h3F);
    chk("switch_busy", {31'd0, busy}, 0);
    chk("switch_sv", {29'd0, slot_valid}, 32'h5);

    // forwarding into an empty slot 2
    save_signal = 0; load_signal = 2; tick();
    save_signal = 2; sensor_input_to_save = 32'hAA; tick();
    chk("fwd_pre_out", sensor_output, 0);
    save_signal = 0; sensor_input_to_save = 0; tick();
    chk("fwd_commit_out", sensor_output, 0);
    chk("fwd_commit_lv", {31'd0, load_valid}, 0);
    tick();
    chk("fwd_out", sensor_output, 32'hAA);
    chk("fwd_lv", {31'd0, load_valid}, 1);
    chk("fwd_sv", {29'd0, slot_valid}, 32'h7);

    // overwrite slot 2 while loading it: old word until the commit edge, then new
    save_signal = 2; sensor_input_to_save = 32'h55; tick();
    chk("ow_cap_out", sensor_output, 32'hAA);
    save_signal = 0; sensor_input_to_save = 0; tick();
    chk("ow_commit_out", sensor_output, 32'hAA);
    tick();
    chk("ow_out", sensor_output, 32'h55);
    chk("ow_sv", {29'd0, slot_valid}, 32'h7);

    // reset during capture
    load_signal = 1;
    save_signal = 1; sensor_input_to_save = 32'h7; tick();
    chk("mid_busy", {31'd0, busy}, 1);
    reset = 1'b1; save_signal = 0; tick();
    reset = 1'b0;
    chk("mid_out", sensor_output, 0);
    chk("mid_lv", {31'd0, load_valid}, 0);
    chk("mid_sv", {29'd0, slot_valid}, 0);
    chk("mid_busy0", {31'd0, busy}, 0);
    done_ref = done_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_nocommit", done_cnt - done_ref, 0);
    chk("mid_sv_after", {29'd0, slot_valid}, 0);
    chk("mid_out_after", sensor_output, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
